// File: rtl/l2_shared_ctrl_pkg.sv
// l2_pkg: shared constants and FSM state type for the two-core L2 controller
package l2_pkg;
  localparam int N          = 32;
  localparam int ADDR_W     = 15;
  localparam int TAG_W      = 5;
  localparam int INDEX_W    = 6;
  localparam int OFFSET_W   = 4;
  localparam int BLOCK_SIZE = 16;
  typedef enum logic [1:0] {IDLE, SERVE, RELEASE} state_t;
endpackage

// File: rtl/l2_shared_ctrl_if.sv
// l2_shared_ctrl_if: L1-facing request/data/snoop bundle for both cores
interface l2_shared_ctrl_if;
  import l2_pkg::*;
  logic               L2_read_request0, L2_read_request1;
  logic               L2_write_request0, L2_write_request1;
  logic [ADDR_W-1:0]  L2_word_address0, L2_word_address1;
  logic [N-1:0]       L2_write_word0, L2_write_word1;
  logic [N-1:0]       L2_read_word0, L2_read_word1;
  logic               L2_busy0, L2_busy1;
  logic               others_read_request0, others_read_request1;
  logic               others_write_request0, others_write_request1;
  logic [TAG_W-1:0]   others_block_tag0, others_block_tag1;
  logic [INDEX_W-1:0] others_block_index0, others_block_index1;
  logic [31:0]        L2_statistics;
  modport master (
    output L2_read_request0, L2_read_request1, L2_write_request0, L2_write_request1,
           L2_word_address0, L2_word_address1, L2_write_word0, L2_write_word1,
    input  L2_read_word0, L2_read_word1, L2_busy0, L2_busy1,
           others_read_request0, others_read_request1, others_write_request0, others_write_request1,
           others_block_tag0, others_block_tag1, others_block_index0, others_block_index1, L2_statistics
  );
  modport slave (
    input  L2_read_request0, L2_read_request1, L2_write_request0, L2_write_request1,
           L2_word_address0, L2_word_address1, L2_write_word0, L2_write_word1,
    output L2_read_word0, L2_read_word1, L2_busy0, L2_busy1,
           others_read_request0, others_read_request1, others_write_request0, others_write_request1,
           others_block_tag0, others_block_tag1, others_block_index0, others_block_index1, L2_statistics
  );
endinterface

// File: rtl/l2_shared_ctrl_rr_arbiter.sv
// l2_rr_arbiter: two-way round-robin owner pick; a tie goes to the core not served last
module l2_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       owner_o
);
  logic last_q, last_d;
  assign owner_o = &req_i ? ~last_q : req_i[1];
  // Remember whoever was granted, so the next tie flips to the other core
  always_comb last_d = take_i ? owner_o : last_q;
  // Starting with core 1 as last-served lets core 0 win the first tie
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= 1'b1;
    else last_q <= last_d;
endmodule

// File: rtl/l2_shared_ctrl.sv
// l2_shared_ctrl: two-core shared L2 backing store with burst ownership and snoops; L2_STATS_EN adds event counters
module l2_shared_ctrl
  import l2_pkg::*;
#(
  parameter int N          = 32,
  parameter int ADDR_W     = 15,
  parameter int BLOCK_SIZE = 16
) (
  input logic            clk,
  input logic            reset,
  l2_shared_ctrl_if.slave bus
);
  localparam int OFF_W = $clog2(BLOCK_SIZE);
  state_t            state_q, state_d;
  logic              owner_q, owner_d, arb_owner;
  logic [1:0]        rd, wr, req;
  logic              own_rd, own_wr, serve, grant, do_rd, do_wr;
  logic [ADDR_W-1:0] own_addr;
  logic [N-1:0]      own_wdata, rword0_q, rword1_q;
  logic [N-1:0]      mem_q [2**ADDR_W];
  assign rd        = {bus.L2_read_request1, bus.L2_read_request0};
  assign wr        = {bus.L2_write_request1, bus.L2_write_request0};
  assign req       = rd | wr;
  assign own_rd    = owner_q ? rd[1] : rd[0];
  assign own_wr    = owner_q ? wr[1] : wr[0];
  assign own_addr  = owner_q ? bus.L2_word_address1 : bus.L2_word_address0;
  assign own_wdata = owner_q ? bus.L2_write_word1 : bus.L2_write_word0;
  assign serve     = state_q == SERVE;
  assign grant     = state_q == IDLE && |req;
  assign do_rd     = serve & own_rd;
  assign do_wr     = serve & own_wr;
  l2_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req),
    .take_i  (grant),
    .owner_o (arb_owner)
  );
  // Owner is latched only at grant and held until its request drops, then one idle RELEASE cycle
  always_comb begin
    state_d = state_q;
    owner_d = grant ? arb_owner : owner_q;
    state_d = grant ? SERVE : serve ? ((own_rd | own_wr) ? SERVE : RELEASE) : IDLE;
  end
  // FSM state and burst owner; reset aborts any burst at once
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  // Read data returns one cycle after the address; the non-owner keeps its last word
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rword0_q <= '0;
      rword1_q <= '0;
    end else begin
      if (do_rd && !owner_q) rword0_q <= mem_q[own_addr];
      if (do_rd && owner_q) rword1_q <= mem_q[own_addr];
    end
  // Backing store is never reset; a same-cycle read still sees the old word
  always_ff @(posedge clk)
    if (do_wr) mem_q[own_addr] <= own_wdata;
  assign bus.L2_read_word0         = rword0_q;
  assign bus.L2_read_word1         = rword1_q;
  assign bus.L2_busy0              = req[0] & ~(serve & ~owner_q);
  assign bus.L2_busy1              = req[1] & ~(serve & owner_q);
  assign bus.others_read_request0  = serve & owner_q & own_rd;
  assign bus.others_read_request1  = serve & ~owner_q & own_rd;
  assign bus.others_write_request0 = serve & owner_q & own_wr;
  assign bus.others_write_request1 = serve & ~owner_q & own_wr;
  assign bus.others_block_tag0     = (serve & owner_q) ? own_addr[ADDR_W-1 -: TAG_W] : '0;
  assign bus.others_block_tag1     = (serve & ~owner_q) ? own_addr[ADDR_W-1 -: TAG_W] : '0;
  assign bus.others_block_index0   = (serve & owner_q) ? own_addr[OFF_W +: INDEX_W] : '0;
  assign bus.others_block_index1   = (serve & ~owner_q) ? own_addr[OFF_W +: INDEX_W] : '0;
`ifdef L2_STATS_EN
  logic [7:0] rd_cnt_q, wr_cnt_q, con_cnt_q, gnt_cnt_q;
  // Free-running 8-bit event counters that simply wrap
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      con_cnt_q <= '0;
      gnt_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_q + 8'(do_rd);
      wr_cnt_q  <= wr_cnt_q + 8'(do_wr);
      con_cnt_q <= con_cnt_q + 8'(&req);
      gnt_cnt_q <= gnt_cnt_q + 8'(grant);
    end
  assign bus.L2_statistics = {rd_cnt_q, wr_cnt_q, con_cnt_q, gnt_cnt_q};
`else
  assign bus.L2_statistics = '0;
`endif
endmodule

// File: tb/tb_l2_shared_ctrl.sv
// tb_l2_shared_ctrl: randomized and directed checks of l2_shared_ctrl against a transaction-level model
module tb_l2_shared_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  l2_shared_ctrl_if bus ();
  l2_shared_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  logic [1:0]  rd = '0, wr = '0;
  logic [14:0] ad [2] = '{15'd0, 15'd0};
  logic [31:0] wd [2] = '{32'd0, 32'd0};
  assign bus.L2_read_request0  = rd[0];
  assign bus.L2_read_request1  = rd[1];
  assign bus.L2_write_request0 = wr[0];
  assign bus.L2_write_request1 = wr[1];
  assign bus.L2_word_address0  = ad[0];
  assign bus.L2_word_address1  = ad[1];
  assign bus.L2_write_word0    = wd[0];
  assign bus.L2_write_word1    = wd[1];
  logic [1:0]  d_busy, d_ors, d_ows;
  logic [4:0]  d_tag [2];
  logic [5:0]  d_idx [2];
  logic [31:0] d_rw [2];
  assign d_busy   = {bus.L2_busy1, bus.L2_busy0};
  assign d_ors    = {bus.others_read_request1, bus.others_read_request0};
  assign d_ows    = {bus.others_write_request1, bus.others_write_request0};
  assign d_tag[0] = bus.others_block_tag0;
  assign d_tag[1] = bus.others_block_tag1;
  assign d_idx[0] = bus.others_block_index0;
  assign d_idx[1] = bus.others_block_index1;
  assign d_rw[0]  = bus.L2_read_word0;
  assign d_rw[1]  = bus.L2_read_word1;
  int pass_n = 0, total_n = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  // Transaction-level model: who holds the store, a one-cycle cooldown after each burst, the store itself
  int          m_own = -1;
  bit          m_cool = 1'b0;
  int          m_last = 1;
  logic [31:0] m_mem [int];
  logic [31:0] m_rw [2] = '{32'd0, 32'd0};
  int          m_rd_n = 0, m_wr_n = 0, m_con_n = 0, m_gnt_n = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_own = -1; m_cool = 1'b0; m_last = 1;
      m_rw[0] = '0; m_rw[1] = '0;
      m_rd_n = 0; m_wr_n = 0; m_con_n = 0; m_gnt_n = 0;
    end else begin
      if ((rd[0] | wr[0]) && (rd[1] | wr[1])) m_con_n++;
      if (m_cool) m_cool = 1'b0;
      else if (m_own < 0) begin
        if ((rd | wr) != 2'b00) begin
          m_own = ((rd[0] | wr[0]) && (rd[1] | wr[1])) ? 1 - m_last : ((rd[1] | wr[1]) ? 1 : 0);
          m_last = m_own;
          m_gnt_n++;
        end
      end else if (rd[m_own] | wr[m_own]) begin
        if (rd[m_own]) begin
          m_rw[m_own] = m_mem.exists(int'(ad[m_own])) ? m_mem[int'(ad[m_own])] : 32'hxxxxxxxx;
          m_rd_n++;
        end
        if (wr[m_own]) begin
          m_mem[int'(ad[m_own])] = wd[m_own];
          m_wr_n++;
        end
      end else begin
        m_own = -1;
        m_cool = 1'b1;
      end
    end
  end
  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    int o;
    bit snp;
    for (int c = 0; c < 2; c++) begin
      o = 1 - c;
      snp = (m_own == o);
      chk($sformatf("busy%0d", c), 32'(d_busy[c]), 32'((rd[c] | wr[c]) && m_own != c));
      chk($sformatf("snoop_rd%0d", c), 32'(d_ors[c]), 32'(snp && rd[o]));
      chk($sformatf("snoop_wr%0d", c), 32'(d_ows[c]), 32'(snp && wr[o]));
      chk($sformatf("snoop_tag%0d", c), 32'(d_tag[c]), snp ? 32'(ad[o][14:10]) : 32'd0);
      chk($sformatf("snoop_idx%0d", c), 32'(d_idx[c]), snp ? 32'(ad[o][9:4]) : 32'd0);
      if (!$isunknown(m_rw[c])) chk($sformatf("read_word%0d", c), d_rw[c], m_rw[c]);
    end
`ifdef L2_STATS_EN
    chk("stats", bus.L2_statistics, {m_rd_n[7:0], m_wr_n[7:0], m_con_n[7:0], m_gnt_n[7:0]});
`else
    chk("stats", bus.L2_statistics, 32'd0);
`endif
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int c, input bit r, input bit w, input logic [14:0] a, input logic [31:0] d);
    rd[c] = r; wr[c] = w; ad[c] = a; wd[c] = d;
  endtask
  task automatic idle(input int c);
    rd[c] = 1'b0; wr[c] = 1'b0;
  endtask
  task automatic settle();
    idle(0); idle(1);
    repeat (3) tick();
  endtask
  // Present one word and hold it until the controller accepts it on a posedge
  task automatic xfer(input int c, input bit r, input bit w, input logic [14:0] a, input logic [31:0] d, output int waited);
    drive(c, r, w, a, d);
    waited = 0;
    @(negedge clk);
    while (d_busy[c] && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) chk("xfer_timeout", 32'(d_busy[c]), 32'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w;
    #1 reset = 1'b0;
    repeat (2) tick();
    chk("rst_rw0", d_rw[0], 32'd0);
    chk("rst_busy", 32'(d_busy), 32'd0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) xfer(0, 1'b0, 1'b1, 15'h0C90 + 15'(i), 32'hA5000000 + i, w);
    xfer(0, 1'b0, 1'b1, 15'h0005, 32'hDEADBEEF, w);
    settle();
    drive(0, 1'b1, 1'b0, 15'h0005, 32'd0);
    @(negedge clk);
    chk("r23_busy_first", 32'(d_busy[0]), 32'd1);
    @(negedge clk);
    chk("r23_busy_granted", 32'(d_busy[0]), 32'd0);
    tick();
    chk("r23_data", d_rw[0], 32'hDEADBEEF);
    settle();
    drive(1, 1'b0, 1'b1, 15'h7C21, 32'h12345678);
    @(negedge clk);
    @(negedge clk);
    chk("r24_snoop_wr0", 32'(d_ows[0]), 32'd1);
    chk("r24_snoop_wr1", 32'(d_ows[1]), 32'd0);
    chk("r24_tag", 32'(d_tag[0]), 32'h1F);
    chk("r24_idx", 32'(d_idx[0]), 32'h02);
    tick();
    settle();
    xfer(0, 1'b1, 1'b0, 15'h7C21, 32'd0, w);
    chk("r24_readback", d_rw[0], 32'h12345678);
    settle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    drive(0, 1'b0, 1'b1, 15'h0C90, 32'hA5000000);
    drive(1, 1'b0, 1'b1, 15'h0C91, 32'hA5000001);
    @(negedge clk);
    chk("r25_tie_busy", 32'(d_busy), 32'd3);
    @(negedge clk);
    chk("r25_tie_winner", 32'(d_busy), 32'd2);
    tick();
    idle(0);
    w = 0;
    @(negedge clk);
    while (d_busy[1] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("r25_core1_wait", w, 32'd3);
    tick();
    settle();
    drive(0, 1'b0, 1'b1, 15'h0C90, 32'hA5000000);
    drive(1, 1'b0, 1'b1, 15'h0C91, 32'hA5000001);
    @(negedge clk);
    @(negedge clk);
    chk("r25_tie2_core0", 32'(d_busy), 32'd2);
    tick();
    settle();
    drive(0, 1'b0, 1'b1, 15'h0C90, 32'hA5000000);
    drive(1, 1'b0, 1'b1, 15'h0C91, 32'hA5000001);
    @(negedge clk);
    @(negedge clk);
    chk("r25_tie3_core1", 32'(d_busy), 32'd1);
    tick();
    settle();
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b1, 1'b0, 15'h0C90 + 15'(i), 32'd0, w);
      chk($sformatf("r26_word%0d", i), d_rw[0], 32'hA5000000 + i);
      if (i > 0) chk("r26_no_stall", w, 32'd0);
      chk("r26_snoop1", 32'(d_ors[1]), 32'd1);
      chk("r26_core1_free", 32'(d_busy[1]), 32'd0);
    end
    settle();
    for (int i = 0; i < 5; i++) xfer(0, 1'b1, 1'b0, 15'h0C90 + 15'(i), 32'd0, w);
    #3 reset = 1'b0;
    #1;
    chk("r27_rw0", d_rw[0], 32'd0);
    chk("r27_rw1", d_rw[1], 32'd0);
    chk("r27_no_grant", 32'(d_busy[0]), 32'd1);
    chk("r27_no_snoop", 32'(d_ors[1]), 32'd0);
    idle(0);
    tick();
    reset = 1'b1;
    settle();
`ifdef L2_STATS_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      xfer(0, 1'b1, 1'b0, 15'h0005, 32'd0, w);
      idle(0);
      repeat (2) tick();
    end
    chk("r28_read_words", 32'(bus.L2_statistics[31:24]), 32'd44);
    chk("r28_grants", 32'(bus.L2_statistics[7:0]), 32'd44);
    chk("r28_write_words", 32'(bus.L2_statistics[23:16]), 32'd0);
`else
    chk("r20_stats_off", bus.L2_statistics, 32'd0);
`endif
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(3) == 0) begin
          if ($urandom_range(9) < 6) begin
            w = int'($urandom_range(2));
            drive(c, w != 1, w != 0, 15'h0C90 + 15'($urandom_range(15)), $urandom);
          end else idle(c);
        end else if ($urandom_range(1) == 0) begin
          ad[c] = 15'h0C90 + 15'($urandom_range(15));
          wd[c] = $urandom;
        end
      tick();
    end
    settle();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/l2_shared_ctrl.md
L2_SHARED_CTRL -- requirements
Module: l2_shared_ctrl

Interface
REQ-001 SHALL have parameters: N = 32, word width; ADDR_W = 15, word-address width; BLOCK_SIZE = 16, words per block.
REQ-002 SHALL have ports:
- clk  in  1  — single clock; all state changes on posedge.
- reset  in  1  — asynchronous, active-low.
- L2_read_request0/1  in  1  — read request from each L1.
- L2_write_request0/1  in  1  — write request from each L1.
- L2_word_address0/1  in  15  — word address from each L1.
- L2_write_word0/1  in  32  — write data from each L1.
- L2_read_word0/1  out  32  — registered read data to each L1.
- L2_busy0/1  out  1  — per-core stall (the L1 clock enable).
- others_read_request0/1  out  1  — snoop read to the core.
- others_write_request0/1  out  1  — snoop write to the core.
- others_block_tag0/1  out  5  — snoop tag (address[14:10]).
- others_block_index0/1  out  6  — snoop index (address[9:4]).
- L2_statistics  out  32  — statistics counters.

Function
REQ-003 SHALL hold a 2^ADDR_W x N backing store covering the full address space, with no tags and no misses.
REQ-004 SHALL implement FSM IDLE -> SERVE -> RELEASE -> IDLE, with a registered owner (0/1).
REQ-005 IDLE: if req_i = read_i|write_i is set for exactly one core, the next state SHALL be SERVE with owner = i.
REQ-006 IDLE with both requesting: owner SHALL be the core not served last (round-robin); after reset, core 0 wins.
REQ-007 SERVE SHALL hold the owner until req_owner = 0, then move to RELEASE; the owner SHALL never change mid-burst.
REQ-008 RELEASE SHALL last exactly one cycle with no grant, then return to IDLE.
REQ-009 L2_busy_i SHALL equal req_i & ~(state==SERVE & owner==i), combinationally; a non-requesting core is never stalled.
REQ-010 In SERVE, on each posedge with read_owner = 1: L2_read_word_owner <= mem[L2_word_address_owner] (one-cycle latency). The non-owner's L2_read_word SHALL hold its value.
REQ-011 In SERVE, on each posedge with write_owner = 1: mem[L2_word_address_owner] <= L2_write_word_owner. Repeated writes to the same address are idempotent.
REQ-012 If read and write are both high in SERVE, the write SHALL take effect and L2_read_word SHALL return the old data.
REQ-013 others_read_request_j SHALL equal read_owner & SERVE; others_write_request_j likewise for write, where j != owner. Both SHALL be 0 outside SERVE.
REQ-014 others_block_tag_j/index_j SHALL be taken from L2_word_address_owner while SERVE, else 0.
REQ-015 Snoops to the owner core SHALL be 0.
REQ-016 A 16-word refill SHALL complete with the owner never stalled after the first grant cycle.

Reset
REQ-017 When reset is low: state = IDLE, owner = 0, last-served = 1, L2_read_word0/1 = 0, statistics = 0, and all outputs derived from these SHALL be 0. Memory contents are not reset.
REQ-018 Reset asserted mid-SERVE SHALL abort the burst immediately. Any partially refilled L1 is that L1's concern.

Configuration
REQ-019 Macro L2_STATS_EN defined: L2_statistics = {read_words[7:0], write_words[7:0], contention_cycles[7:0], grants[7:0]}, all wrapping at 255. contention_cycles counts cycles with both req high.
REQ-020 L2_STATS_EN undefined: no counters; L2_statistics = 0.

Structure
REQ-021 Package l2_pkg SHALL hold the state enum and the N/ADDR_W/TAG_W(5)/INDEX_W(6)/OFFSET_W(4) constants.
REQ-022 Sub-module l2_rr_arbiter SHALL contain the 2-way round-robin owner selection and the last-served register.

Verification
REQ-023 Single core 0 read of address 0x0005 with mem = 0xDEADBEEF -> L2_busy0 = 1 for one cycle, then L2_read_word0 = 0xDEADBEEF one cycle after the address is granted.
REQ-024 Core 1 write of 0x12345678 to 0x7C21 -> mem[0x7C21] = 0x12345678; others_write_request0 = 1 with tag = 0x1F and index = 0x02 during SERVE.
REQ-025 Both request in the same cycle after reset -> core 0 served first, L2_busy1 = 1 until core 0 releases and one RELEASE cycle passes, then core 1 served. The next tie goes to core 0 again only after core 1 has been served.
REQ-026 Full 16-word refill by core 0 of block tag 3, index 9 -> words 0..15 returned in order; others_read_request1 high throughout; core 1 idle with L2_busy1 = 0.
REQ-027 Reset pulled low mid-refill -> state IDLE and L2_read_word0/1 = 0 asynchronously.
REQ-028 With L2_STATS_EN defined: 300 single-word reads -> read_words = 44 (wrap).
